// File: rtl/mby_msh_wr_req_tx_pkg.sv
// Shared widths, defaults and flit types for the mesh write-request transmitter.
// The top module takes these as parameter defaults so one package serves every side.
package mby_msh_wr_req_tx_pkg;

    localparam int MSH_REQ_W      = 64;
    localparam int MSH_DBUS_W     = 512;
    localparam int MSH_FIFO_DEPTH = 4;
    localparam int MSH_WR_CRDTS   = 8;
    localparam int MSH_RTN_W      = 2;

    typedef logic [MSH_REQ_W-1:0]  msh_wr_req_t;
    typedef logic [MSH_DBUS_W-1:0] msh_wr_dbus_t;

    typedef struct packed {
        msh_wr_req_t  req;
        msh_wr_dbus_t dbus;
    } msh_wr_flit_t;

endpackage

// File: rtl/mby_msh_wr_req_tx_fifo.sv
// Parameterised synchronous circular-buffer FIFO shared by the mesh request transmitters.
// DEPTH must be a power of two so the pointers wrap naturally.
module mby_msh_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mby_msh_wr_req_tx.sv
// Credit-managed write-request injector for one mesh-node input side.
// Buffers client flits and forwards them to the node only while a downstream credit is held.
module mby_msh_wr_req_tx
    import mby_msh_wr_req_tx_pkg::*;
#(
    parameter int REQ_W      = MSH_REQ_W,
    parameter int DBUS_W     = MSH_DBUS_W,
    parameter int FIFO_DEPTH = MSH_FIFO_DEPTH,
    parameter int NUM_CRDTS  = MSH_WR_CRDTS,
    parameter int RTN_W      = MSH_RTN_W
) (
    input  logic                             mclk,
    input  logic                             mhreset_n,
    input  logic                             i_req_vld,
    input  logic [REQ_W-1:0]                 i_req,
    input  logic [DBUS_W-1:0]                i_dbus,
    output logic                             o_req_rdy,
    output logic                             o_wr_req_vld,
    output logic [REQ_W-1:0]                 o_wr_req,
    output logic [DBUS_W-1:0]                o_wr_dbus,
    input  logic [RTN_W-1:0]                 i_crdt_rtn,
    output logic [$clog2(NUM_CRDTS+1)-1:0]   o_crdt_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_cnt,
    output logic                             o_crdt_ovfl,
    output logic                             o_idle
);

    localparam int CCW = $clog2(NUM_CRDTS+1);
    localparam int FCW = $clog2(FIFO_DEPTH+1);
    localparam int SW  = $clog2(NUM_CRDTS+RTN_W+1);
    localparam int FW  = REQ_W + DBUS_W;

    logic [CCW-1:0]    crdt_q, crdt_d;
    logic              ovfl_q, ovfl_d;
    logic              vld_q;
    logic [REQ_W-1:0]  req_q;
    logic [DBUS_W-1:0] dbus_q;

    logic [FW-1:0]     head_flit;
    logic [FCW-1:0]    fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic              push, send;
    logic [SW-1:0]     rtn_cnt, crdt_sum;

    // Ready looks only at registered occupancy, so returns never reach it combinationally.
    assign o_req_rdy = mhreset_n && !fifo_full;
    assign push      = i_req_vld && o_req_rdy;
    assign send      = !fifo_empty && (crdt_q != '0);

    mby_msh_req_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (mclk),
        .rst_n_i     (mhreset_n),
        .push_i      (push),
        .push_data_i ({i_req, i_dbus}),
        .pop_i       (send),
        .pop_data_o  (head_flit),
        .count_o     (fifo_cnt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        rtn_cnt = '0;
        for (int i = 0; i < RTN_W; i++) begin
            rtn_cnt = rtn_cnt + SW'(i_crdt_rtn[i]);
        end
    end

    // A send always has a credit behind it, so the subtraction cannot underflow.
    assign crdt_sum = SW'(crdt_q) - SW'(send) + rtn_cnt;

    always_comb begin
        crdt_d = CCW'(crdt_sum);
        ovfl_d = ovfl_q;
        if (crdt_sum > SW'(NUM_CRDTS)) begin
            crdt_d = CCW'(NUM_CRDTS);
            ovfl_d = 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (!mhreset_n) begin
            crdt_q <= CCW'(NUM_CRDTS);
            ovfl_q <= 1'b0;
            vld_q  <= 1'b0;
            req_q  <= '0;
            dbus_q <= '0;
        end else begin
            crdt_q <= crdt_d;
            ovfl_q <= ovfl_d;
            vld_q  <= send;
            if (send) begin
                req_q  <= head_flit[FW-1:DBUS_W];
                dbus_q <= head_flit[DBUS_W-1:0];
            end
        end
    end

    assign o_wr_req_vld = vld_q;
    assign o_wr_req     = req_q;
    assign o_wr_dbus    = dbus_q;
    assign o_crdt_cnt   = crdt_q;
    assign o_fifo_cnt   = fifo_cnt;
    assign o_crdt_ovfl  = ovfl_q;
    assign o_idle       = fifo_empty && (crdt_q == CCW'(NUM_CRDTS));

endmodule

// File: tb/tb_mby_msh_wr_req_tx.sv
// Bench for mby_msh_wr_req_tx: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based model of the transmitter.
module tb_mby_msh_wr_req_tx;

    localparam int REQ_W      = 64;
    localparam int DBUS_W     = 512;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM_CRDTS  = 8;
    localparam int RTN_W      = 2;
    localparam int CCW        = $clog2(NUM_CRDTS+1);
    localparam int FCW        = $clog2(FIFO_DEPTH+1);
    localparam int NVEC       = 12;

    logic              mclk = 1'b0;
    logic              mhreset_n;
    logic              i_req_vld;
    logic [REQ_W-1:0]  i_req;
    logic [DBUS_W-1:0] i_dbus;
    logic              o_req_rdy;
    logic              o_wr_req_vld;
    logic [REQ_W-1:0]  o_wr_req;
    logic [DBUS_W-1:0] o_wr_dbus;
    logic [RTN_W-1:0]  i_crdt_rtn;
    logic [CCW-1:0]    o_crdt_cnt;
    logic [FCW-1:0]    o_fifo_cnt;
    logic              o_crdt_ovfl;
    logic              o_idle;

    mby_msh_wr_req_tx #(
        .REQ_W      (REQ_W),
        .DBUS_W     (DBUS_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .NUM_CRDTS  (NUM_CRDTS),
        .RTN_W      (RTN_W)
    ) dut (
        .mclk         (mclk),
        .mhreset_n    (mhreset_n),
        .i_req_vld    (i_req_vld),
        .i_req        (i_req),
        .i_dbus       (i_dbus),
        .o_req_rdy    (o_req_rdy),
        .o_wr_req_vld (o_wr_req_vld),
        .o_wr_req     (o_wr_req),
        .o_wr_dbus    (o_wr_dbus),
        .i_crdt_rtn   (i_crdt_rtn),
        .o_crdt_cnt   (o_crdt_cnt),
        .o_fifo_cnt   (o_fifo_cnt),
        .o_crdt_ovfl  (o_crdt_ovfl),
        .o_idle       (o_idle)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [REQ_W-1:0]  req;
        logic [DBUS_W-1:0] dbus;
    } flit_t;

    typedef struct {
        logic       rstN;
        logic       vld;
        logic [7:0] reqByte;
        logic [1:0] rtn;
        logic       expVld;
        logic [7:0] expReqByte;
        logic [3:0] expCrdt;
        logic [2:0] expFifo;
        logic       expRdy;
        logic       expIdle;
        logic       expOvfl;
    } vec_t;

    flit_t             mQ[$];
    int                mCrd;
    bit                mOvfl;
    bit                mVld;
    logic [REQ_W-1:0]  mReq;
    logic [DBUS_W-1:0] mDbus;

    int   compared   = 0;
    int   mismatched = 0;
    int   vldSeen    = 0;
    logic rdySeen;
    vec_t vecs[NVEC];

    function automatic logic [DBUS_W-1:0] dbusOf(input logic [7:0] b);
        logic [7:0] p;
        p = b + 8'h99;
        return (b == 8'h00) ? '0 : {64{p}};
    endfunction

    // The node model: a flit queue, a credit integer and a one-deep output stage.
    task automatic modelEdge(input logic rstN, input logic vld, input logic [REQ_W-1:0] req,
                             input logic [DBUS_W-1:0] dbus, input logic [RTN_W-1:0] rtn);
        int    sum;
        bit    accept;
        bit    send;
        flit_t f;
        if (!rstN) begin
            mQ.delete();
            mCrd  = NUM_CRDTS;
            mOvfl = 1'b0;
            mVld  = 1'b0;
            mReq  = '0;
            mDbus = '0;
        end else begin
            accept = vld && (mQ.size() < FIFO_DEPTH);
            send   = (mQ.size() > 0) && (mCrd > 0);
            sum    = mCrd - int'(send) + $countones(rtn);
            if (sum > NUM_CRDTS) begin
                sum   = NUM_CRDTS;
                mOvfl = 1'b1;
            end
            mCrd = sum;
            mVld = send;
            if (send) begin
                f     = mQ.pop_front();
                mReq  = f.req;
                mDbus = f.dbus;
            end
            if (accept) begin
                f.req  = req;
                f.dbus = dbus;
                mQ.push_back(f);
            end
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic vld, input logic [REQ_W-1:0] req,
                                 input logic [DBUS_W-1:0] dbus, input logic [RTN_W-1:0] rtn);
        mhreset_n  = rstN;
        i_req_vld  = vld;
        i_req      = req;
        i_dbus     = dbus;
        i_crdt_rtn = rtn;
        #1;
        rdySeen = o_req_rdy;
        @(posedge mclk);
        modelEdge(rstN, vld, req, dbus, rtn);
        #1;
        if (o_wr_req_vld === 1'b1) vldSeen++;
    endtask

    task automatic checkOutput(input string name, input logic [DBUS_W-1:0] act,
                               input logic [DBUS_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput({name, ".vld"},  DBUS_W'(o_wr_req_vld), DBUS_W'(mVld));
        checkOutput({name, ".req"},  DBUS_W'(o_wr_req), DBUS_W'(mReq));
        checkOutput({name, ".dbus"}, o_wr_dbus, mDbus);
        checkOutput({name, ".crdt"}, DBUS_W'(o_crdt_cnt), DBUS_W'(mCrd));
        checkOutput({name, ".fifo"}, DBUS_W'(o_fifo_cnt), DBUS_W'(mQ.size()));
        checkOutput({name, ".rdy"},  DBUS_W'(o_req_rdy),
                    DBUS_W'(mhreset_n && (mQ.size() < FIFO_DEPTH)));
        checkOutput({name, ".idle"}, DBUS_W'(o_idle),
                    DBUS_W'((mQ.size() == 0) && (mCrd == NUM_CRDTS)));
        checkOutput({name, ".ovfl"}, DBUS_W'(o_crdt_ovfl), DBUS_W'(mOvfl));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int               k;
        logic [7:0]       b;
        logic [REQ_W-1:0] rq;
        logic [DBUS_W-1:0] rd;
        logic [RTN_W-1:0] rtn;
        logic             rstN;
        bit               pend;
        int               avail;
        int               used;

        // rstN vld req rtn | vld req crdt fifo rdy idle ovfl
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 4'd8, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 2'b11, 1'b0, 8'h00, 4'd8, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h11, 2'b00, 1'b0, 8'h00, 4'd8, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 8'h11, 4'd7, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h11, 4'd7, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 2'b01, 1'b0, 8'h11, 4'd8, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'h22, 2'b00, 1'b0, 8'h11, 4'd8, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 8'h33, 2'b01, 1'b1, 8'h22, 4'd8, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 8'h33, 4'd8, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 8'h33, 4'd8, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h33, 4'd8, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 4'd8, 3'd0, 1'b0, 1'b1, 1'b0};

        mhreset_n  = 1'b0;
        i_req_vld  = 1'b0;
        i_req      = '0;
        i_dbus     = '0;
        i_crdt_rtn = '0;
        @(posedge mclk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].vld, REQ_W'(vecs[i].reqByte),
                          dbusOf(vecs[i].reqByte), vecs[i].rtn);
            checkOutput($sformatf("vec%0d.vld", i), DBUS_W'(o_wr_req_vld), DBUS_W'(vecs[i].expVld));
            checkOutput($sformatf("vec%0d.req", i), DBUS_W'(o_wr_req), DBUS_W'(vecs[i].expReqByte));
            checkOutput($sformatf("vec%0d.dbus", i), o_wr_dbus, dbusOf(vecs[i].expReqByte));
            checkOutput($sformatf("vec%0d.crdt", i), DBUS_W'(o_crdt_cnt), DBUS_W'(vecs[i].expCrdt));
            checkOutput($sformatf("vec%0d.fifo", i), DBUS_W'(o_fifo_cnt), DBUS_W'(vecs[i].expFifo));
            checkOutput($sformatf("vec%0d.rdy", i), DBUS_W'(o_req_rdy), DBUS_W'(vecs[i].expRdy));
            checkOutput($sformatf("vec%0d.idle", i), DBUS_W'(o_idle), DBUS_W'(vecs[i].expIdle));
            checkOutput($sformatf("vec%0d.ovfl", i), DBUS_W'(o_crdt_ovfl), DBUS_W'(vecs[i].expOvfl));
        end

        // Twelve back-to-back flits with no returns: eight go out, four stay queued.
        k       = 0;
        vldSeen = 0;
        for (int c = 0; c < 20 && k < 12; c++) begin
            b = 8'h40 + 8'(k);
            applyStimulus(1'b1, 1'b1, REQ_W'(b), dbusOf(b), 2'b00);
            if (rdySeen) k++;
            checkModel("burst");
        end
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00);
        checkModel("burst_idle");
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00);
        checkModel("burst_idle");
        checkOutput("burst_sent", DBUS_W'(vldSeen), DBUS_W'(8));
        checkOutput("burst_crdt", DBUS_W'(o_crdt_cnt), DBUS_W'(0));
        checkOutput("burst_fifo", DBUS_W'(o_fifo_cnt), DBUS_W'(4));
        checkOutput("burst_rdy", DBUS_W'(o_req_rdy), DBUS_W'(0));

        // A return at zero credit only enables the send on the following edge.
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b01);
        checkOutput("rtn_no_same_cycle", DBUS_W'(o_wr_req_vld), DBUS_W'(0));
        checkOutput("rtn_crdt", DBUS_W'(o_crdt_cnt), DBUS_W'(1));
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b00);
        checkOutput("flit9_vld", DBUS_W'(o_wr_req_vld), DBUS_W'(1));
        checkOutput("flit9_req", DBUS_W'(o_wr_req), DBUS_W'(8'h48));
        checkModel("flit9");

        applyStimulus(1'b1, 1'b0, '0, '0, 2'b11);
        checkOutput("prerst_crdt", DBUS_W'(o_crdt_cnt), DBUS_W'(2));
        checkOutput("prerst_fifo", DBUS_W'(o_fifo_cnt), DBUS_W'(3));

        // Mid-operation reset with returns arriving in the reset cycle.
        applyStimulus(1'b0, 1'b1, REQ_W'(8'h77), dbusOf(8'h77), 2'b11);
        checkOutput("rst_fifo", DBUS_W'(o_fifo_cnt), DBUS_W'(0));
        checkOutput("rst_crdt", DBUS_W'(o_crdt_cnt), DBUS_W'(8));
        checkOutput("rst_ovfl", DBUS_W'(o_crdt_ovfl), DBUS_W'(0));
        checkOutput("rst_rdy", DBUS_W'(o_req_rdy), DBUS_W'(0));
        vldSeen = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, 2'b00);
            checkModel("post_rst");
        end
        checkOutput("post_rst_no_vld", DBUS_W'(vldSeen), DBUS_W'(0));

        // Six pushes bring the count to 3, then a send with two returns nets out to 4.
        for (int c = 0; c < 6; c++) begin
            b = 8'h60 + 8'(c);
            applyStimulus(1'b1, 1'b1, REQ_W'(b), dbusOf(b), 2'b00);
            checkModel("to_three");
        end
        checkOutput("cnt3_crdt", DBUS_W'(o_crdt_cnt), DBUS_W'(3));
        applyStimulus(1'b1, 1'b0, '0, '0, 2'b11);
        checkOutput("net_crdt", DBUS_W'(o_crdt_cnt), DBUS_W'(4));
        checkOutput("net_vld", DBUS_W'(o_wr_req_vld), DBUS_W'(1));
        checkOutput("net_req", DBUS_W'(o_wr_req), DBUS_W'(8'h65));
        checkModel("net");

        // Random traffic: client holds a refused flit, node returns only credits it owes.
        pend = 1'b0;
        rq   = '0;
        rd   = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && ($urandom_range(0, 9) < 6)) begin
                pend = 1'b1;
                rq   = {$urandom, $urandom};
                for (int w = 0; w < DBUS_W / 32; w++) rd[w*32 +: 32] = $urandom;
            end
            rstN  = ($urandom_range(0, 299) != 0);
            avail = NUM_CRDTS - mCrd;
            used  = 0;
            rtn   = '0;
            for (int r = 0; r < RTN_W; r++) begin
                if (used < avail && $urandom_range(0, 2) == 0) begin
                    rtn[r] = 1'b1;
                    used++;
                end
            end
            applyStimulus(rstN, pend, rq, rd, rtn);
            if (pend && rdySeen) pend = 1'b0;
            checkModel("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mby_msh_wr_req_tx.md
Name: mby_msh_wr_req_tx

Overview:
- Credit-managed write-request injector on one mesh-node input side (nb/sb/eb/wb); one instance per side.
- Accepts write request plus data-bus flits from the local client over a valid/ready handshake and buffers them in a small FIFO.
- Drives the node's i_*_wr_req / i_*_wr_dbus only when a downstream credit is held; consumes the node's o_*_crdt_rtn(s)_for_*_wr_req(s) returns.

Parameters:
- REQ_W, 64, width of the write-request header (mby_msh_pkg request type width).
- DBUS_W, 512, width of the write data bus.
- FIFO_DEPTH, 4, entries in the request FIFO; power of 2, ≥2.
- NUM_CRDTS, 8, initial and maximum credit count (node input buffer depth).
- RTN_W, 2, credit-return lanes per cycle (1 for nb/sb, 2 for eb/wb).

Ports:
- mclk  in  1  mesh clock; all logic on posedge.
- mhreset_n  in  1  reset, synchronous, active-low.
- i_req_vld  in  1  client flit valid.
- i_req  in  REQ_W  client request header.
- i_dbus  in  DBUS_W  client write data.
- o_req_rdy  out  1  FIFO can accept; transfer when i_req_vld && o_req_rdy.
- o_wr_req_vld  out  1  flit valid to mesh node, registered.
- o_wr_req  out  REQ_W  header to node, registered.
- o_wr_dbus  out  DBUS_W  data to node, registered.
- i_crdt_rtn  in  RTN_W  one bit per returned credit this cycle.
- o_crdt_cnt  out  $clog2(NUM_CRDTS+1)  credits currently held.
- o_fifo_cnt  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- o_crdt_ovfl  out  1  sticky error: credit count would exceed NUM_CRDTS.
- o_idle  out  1  FIFO empty and o_crdt_cnt == NUM_CRDTS.

Behaviour:
- Reset (mhreset_n==0 at posedge): FIFO flushed, o_fifo_cnt=0, o_crdt_cnt=NUM_CRDTS, o_wr_req_vld=0, o_wr_req=0, o_wr_dbus=0, o_crdt_ovfl=0, o_req_rdy=0 during reset, o_idle=1. Reset mid-operation discards queued flits and restores full credit. Returns arriving in the reset cycle are ignored.
- o_req_rdy = (o_fifo_cnt < FIFO_DEPTH), combinational from state only. It does not depend on same-cycle pop, so there is no comb path from i_crdt_rtn.
- Send condition: send = fifo_not_empty && (o_crdt_cnt != 0).
- On send, the head is popped and registered into o_wr_req/o_wr_dbus with o_wr_req_vld=1 for exactly one cycle. Otherwise o_wr_req_vld=0 and data holds its last value.
- Latency: flit accepted at edge N into an empty FIFO with credit → o_wr_req_vld high after edge N+1. Throughput is 1 flit/cycle while credits last.
- Credit arithmetic: next = cnt − send + popcount(i_crdt_rtn).
  - Simultaneous send and return nets out; a return at cnt==0 enables a send the following cycle, not the same cycle.
  - If next > NUM_CRDTS: saturate at NUM_CRDTS and set o_crdt_ovfl (sticky until reset).
- FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle when full is allowed only if o_req_rdy was high, i.e. never at full.
  - Push and pop in the same cycle at count 1 keeps count 1 and ordering.
- Ordering: strict FIFO; no reordering, no drop.
- i_req_vld while o_req_rdy=0: flit is not taken; the client must hold it.

Decomposition:
- mby_msh_pkg: REQ_W/DBUS_W-derived types msh_wr_req_t and msh_wr_dbus_t; MSH_WR_CRDTS default constant.
- msh_node_sim_pkg: credit-check helper for the bench.
- Sub-module mby_msh_req_fifo: parameterised width/depth sync FIFO with push/pop/count/full/empty, reusable for the rd_req/rd_rsp transmitters.
- Top level: credit counter, send logic, output register.

Test Plan:
- Reset then idle → o_crdt_cnt=8, o_fifo_cnt=0, o_idle=1, o_req_rdy=1, o_wr_req_vld=0.
- Push 1 flit (req=0x11, dbus=0xAA..) at edge N, no returns → o_wr_req_vld=1 only in cycle after N+1 with matching data; o_crdt_cnt=7.
- Push 12 back-to-back flits, no returns → exactly 8 sent in order.
  - o_crdt_cnt=0, FIFO holds 4, o_req_rdy=0.
  - Then one return (i_crdt_rtn=2'b01) → flit 9 sent one cycle later.
- Sustained stream with i_crdt_rtn=2'b01 every cycle at cnt=8 → no net change.
  - Inject i_crdt_rtn=2'b11 at cnt=8 → o_crdt_ovfl=1, cnt stays 8.
- Send and 2 returns in the same cycle at cnt=3 → cnt=4.
- Reset asserted with FIFO=3, cnt=2 → next cycle FIFO=0, cnt=8, no o_wr_req_vld after release until a new push.
